// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters with
// round-robin grant, registers results back per port and owns the Z/V/N
// flag register (updated from port-0 operations only).

// Per-port response register: pulses valid for the cycle after a grant
// and keeps the last result until that port is granted again.
module alu_arbiter_rsp (
  input  logic        clk,
  input  logic        rst,
  input  logic        grant,
  input  logic [15:0] alu_out,
  output logic        rsp_valid,
  output logic [15:0] rsp_data
);
  logic        valid_d, valid_q;
  logic [15:0] data_d, data_q;

  // capture the ALU result only when this port won the cycle
  always_comb begin
    valid_d = grant;
    data_d  = data_q;
    if (grant) data_d = alu_out;
  end

  // response state, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= 16'h0000;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign rsp_valid = valid_q;
  assign rsp_data  = data_q;
endmodule

module alu_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        req0_valid,
  input  logic [3:0]  req0_opcode,
  input  logic [15:0] req0_in1,
  input  logic [15:0] req0_in2,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [3:0]  req1_opcode,
  input  logic [15:0] req1_in1,
  input  logic [15:0] req1_in2,
  output logic        req1_ready,
  output logic        rsp0_valid,
  output logic [15:0] rsp0_data,
  output logic        rsp1_valid,
  output logic [15:0] rsp1_data,
  output logic [3:0]  alu_opcode,
  output logic [15:0] alu_in1,
  output logic [15:0] alu_in2,
  input  logic [15:0] alu_out,
  input  logic        z_set,
  input  logic        v_set,
  input  logic        n_set,
  output logic [2:0]  flags,
  output logic        err_pulse
);
  localparam int NP = 2;
  localparam int DW = 16;
  localparam int OW = 4;

  logic [NP-1:0]         req_valid;
  logic [NP-1:0][OW-1:0] req_op;
  logic [NP-1:0][DW-1:0] req_a, req_b;
  logic [NP-1:0]         grant;
  logic [NP-1:0]         rsp_valid;
  logic [NP-1:0][DW-1:0] rsp_data;
  logic                  sel;

  // last_grant holds the index of the port that won the most recent transfer
  logic       last_grant_d, last_grant_q;
  logic [2:0] flags_d, flags_q;   // {Z,V,N}
  logic       err_d, err_q;

  assign req_valid = {req1_valid, req0_valid};
  assign req_op    = {req1_opcode, req0_opcode};
  assign req_a     = {req1_in1, req0_in1};
  assign req_b     = {req1_in2, req0_in2};

  // round-robin grant; reset and hold suppress every grant
  always_comb begin
    grant = '0;
    if (!rst && !hold) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
        default: grant = '0;
      endcase
    end
  end

  assign sel        = grant[1];
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  // ALU operand mux: winner passes through, idle drives zeros
  always_comb begin
    alu_opcode = '0;
    alu_in1    = '0;
    alu_in2    = '0;
    if (|grant) begin
      alu_opcode = req_op[sel];
      alu_in1    = req_a[sel];
      alu_in2    = req_b[sel];
    end
  end

  // next-state for arbitration pointer, flags and error pulse
  always_comb begin
    last_grant_d = last_grant_q;
    flags_d      = flags_q;
    err_d        = 1'b0;
    if (|grant) begin
      last_grant_d = sel;
      err_d        = (alu_opcode[3:2] == 2'b11);
    end
    if (grant[0]) begin
      case (req0_opcode)
        4'h0, 4'h1:             flags_d = {z_set, v_set, n_set};
        4'h2, 4'h4, 4'h5, 4'h6: flags_d[2] = z_set;
        default:                flags_d = flags_q;
      endcase
    end
  end

  // arbitration pointer, flags and error pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      flags_q      <= 3'b000;
      err_q        <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      flags_q      <= flags_d;
      err_q        <= err_d;
    end
  end

  for (genvar p = 0; p < NP; p++) begin : g_rsp
    alu_arbiter_rsp u_rsp (
      .clk       (clk),
      .rst       (rst),
      .grant     (grant[p]),
      .alu_out   (alu_out),
      .rsp_valid (rsp_valid[p]),
      .rsp_data  (rsp_data[p])
    );
  end

  assign rsp0_valid = rsp_valid[0];
  assign rsp0_data  = rsp_data[0];
  assign rsp1_valid = rsp_valid[1];
  assign rsp1_data  = rsp_data[1];
  assign flags      = flags_q;
  assign err_pulse  = err_q;
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational ALU between two requesters: port 0 (execute stage) and port 1 (memory address generation / auxiliary). The block grants one request per cycle with round-robin fairness and drives the ALU operands and opcode from the winner. It registers the result back to the winning port one cycle later and owns the architectural Z/V/N flag register, updating it only from port-0 operations.

## Interface
- No parameters; data width fixed at 16, opcode width fixed at 4.
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- hold  in  1  pipeline stall; while high no request is granted
- req0_valid  in  1  port-0 request present
- req0_opcode  in  4  port-0 ALU opcode
- req0_in1, req0_in2  in  16 each  port-0 operands
- req0_ready  out  1  port-0 granted this cycle (combinational)
- req1_valid / req1_opcode / req1_in1 / req1_in2 / req1_ready  same as port 0, for port 1
- rsp0_valid  out  1  one-cycle pulse: port-0 result available
- rsp0_data  out  16  port-0 result, held until next port-0 response
- rsp1_valid, rsp1_data  out  1, 16  same for port 1
- alu_opcode  out  4  to ALU Opcode
- alu_in1, alu_in2  out  16 each  to ALU operands
- alu_out  in  16  ALU result
- z_set, v_set, n_set  in  1 each  ALU flag-set outputs
- flags  out  3  architectural {Z,V,N}
- err_pulse  out  1  one-cycle pulse: an invalid opcode (0xC–0xF) was executed

## Operation
- Handshake: a request transfers when reqN_valid && reqN_ready. A requester holds its opcode and operands stable while valid && !ready, and may drop valid only after transfer.
- Grant is combinational from valid, hold, and the last_grant register. At most one ready is high per cycle. hold=1 forces both readies low.
- Only one port valid: that port is granted.
- Both valid: the port not equal to last_grant is granted. last_grant updates to the granted port on each transfer; with no transfer it is unchanged.
- ALU drive: the granted port's opcode and operands pass straight through to alu_opcode, alu_in1 and alu_in2. With no grant the block drives alu_opcode=4'h0 and both operands 16'h0000.
- Result capture on the edge ending the grant cycle:
  - rspN_data <= alu_out and rspN_valid <= 1 for the granted port.
  - The other port's rsp_valid <= 0 and its rsp_data is unchanged.
- Flag update, port-0 transfers only, on the same edge:
  - Opcodes 0x0, 0x1 (ADD/SUB): Z <= z_set, V <= v_set, N <= n_set.
  - Opcodes 0x2, 0x4, 0x5, 0x6 (XOR/SLL/SRA/ROR): Z <= z_set; V and N are held.
  - All other opcodes: no flag change.
- Port-1 transfers never modify flags.
- Invalid opcodes 0xC–0xF are still granted and produce a response (data 0x0000 from the ALU). They leave flags unchanged, and err_pulse goes high the following cycle.

## Timing
- Latency: exactly 1 cycle from transfer edge to rspN_valid high. Throughput: one operation per cycle in total across both ports.
- Reset values (rst high at an edge):
  - last_grant=1, so port 0 wins the first contention.
  - rsp0_valid=rsp1_valid=0, rsp0_data=rsp1_data=0x0000.
  - flags=3'b000, err_pulse=0.
- While rst is high, both readies are forced to 0.
- Reset mid-operation: a transfer in the cycle rst is high is discarded. No response pulse follows it and no flags update.
- A hold rising in the same cycle as valid: no transfer. A response from the previous cycle's transfer still pulses normally.
- Back-to-back port-0 transfers: rsp0_valid stays high for consecutive cycles, with rsp0_data updating each cycle.
- Continuous contention yields strict alternation 0,1,0,1,…

## Test plan
- Reset, then req0 ADD 0x0003+0x0004 alone → req0_ready=1 same cycle; next cycle rsp0_valid=1, rsp0_data=0x0007, flags=000.
- Both ports valid for 4 cycles (port0 SUB 0x8000−0x0001, port1 LW opcode 0x8) → grants 0,1,0,1. Port-0 response is 0x8000 (saturated) with flags Z=0,V=1,N=1. Port-1 responses leave flags unchanged.
- Port0 XOR 0x00FF^0x00FF after ADD set V=1,N=1 → rsp0_data=0x0000, flags Z=1,V=1,N=1.
- hold=1 with both valid for 3 cycles → both readies 0 and no rsp pulses. On hold release, port 0 is granted first (last_grant=1).
- Port0 opcode 0xD → rsp0_data=0x0000, err_pulse=1 one cycle later, flags unchanged.
- rst asserted in the same cycle as a granted req1 → no rsp1_valid next cycle, rsp1_data=0x0000, flags=000.
